// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the RAM burst initiator and its read buffer.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam int unsigned DEF_DEPTH  = 256;
    localparam int unsigned DEF_DWIDTH = 8;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned DEF_AWIDTH = addr_width(DEF_DEPTH);

    typedef struct packed {
        logic                  write;
        logic [DEF_AWIDTH-1:0] addr;
        logic [DEF_AWIDTH-1:0] len;
    } cmd_t;

endpackage

// File: rtl/ram_rd_buf.sv
// Synchronous FIFO holding RAM read data until the consumer accepts it.
module ram_rd_buf
    import ram_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = addr_width(DEPTH),
    localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [OCC_W-1:0] occ,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push  = push && (occ_q != OCC_W'(DEPTH));
        do_pop   = pop && (occ_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign occ      = occ_q;
    assign empty    = (occ_q == '0);
    assign full     = (occ_q == OCC_W'(DEPTH));

endmodule

// File: rtl/ram_burst_initiator.sv
// Burst command engine driving the RAM ports with single-beat accesses,
// wrapping addresses, and a credit-limited read-return buffer.
module ram_burst_initiator
    import ram_pkg::*;
#(
    parameter  int unsigned DEPTH      = DEF_DEPTH,
    parameter  int unsigned DWIDTH     = DEF_DWIDTH,
    parameter  int unsigned RD_LAT     = 1,
    parameter  int unsigned RBUF_DEPTH = 4,
    localparam int unsigned AWIDTH     = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH-1:0] cmd_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [DWIDTH-1:0] wdat_data,
    output logic              rdat_valid,
    input  logic              rdat_ready,
    output logic [DWIDTH-1:0] rdat_data,
    output logic              busy,
    output logic              done,
    output logic              wr_enbl,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              rd_enbl,
    output logic [AWIDTH-1:0] rd_addr,
    input  logic [DWIDTH-1:0] rd_data
);

    localparam int unsigned       OCC_W     = $clog2(RBUF_DEPTH + 1);
    localparam int unsigned       CNT_W     = $clog2(RBUF_DEPTH + RD_LAT + 2);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    state_t              state_q, state_d;
    logic                init_q;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [AWIDTH:0]     beats_q, beats_d;
    logic [AWIDTH:0]     deliver_q, deliver_d;
    logic                wr_enbl_q, wr_enbl_d;
    logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DWIDTH-1:0]   wr_data_q, wr_data_d;
    logic                rd_enbl_q, rd_enbl_d;
    logic [AWIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [RD_LAT:0]     pipe_q, pipe_d;

    logic                wr_accept, issue, push, pop;
    logic                buf_empty, buf_full;
    logic [OCC_W-1:0]    buf_occ;
    logic [CNT_W-1:0]    outstanding;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            init_q    <= 1'b0;
            addr_q    <= '0;
            beats_q   <= '0;
            deliver_q <= '0;
            wr_enbl_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_enbl_q <= 1'b0;
            rd_addr_q <= '0;
            pipe_q    <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= 1'b1;
            addr_q    <= addr_d;
            beats_q   <= beats_d;
            deliver_q <= deliver_d;
            wr_enbl_q <= wr_enbl_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_enbl_q <= rd_enbl_d;
            rd_addr_q <= rd_addr_d;
            pipe_q    <= pipe_d;
        end
    end

    // beats_q counts beats still to accept/issue; deliver_q counts read beats still to hand over.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        deliver_d = deliver_q;
        wr_enbl_d = wr_accept;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_enbl_d = issue;
        rd_addr_d = rd_addr_q;
        pipe_d[0] = issue;
        for (int unsigned i = 1; i <= RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr;
                    beats_d   = {1'b0, cmd_len} + 1'b1;
                    deliver_d = {1'b0, cmd_len} + 1'b1;
                    state_d   = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_accept) begin
                    wr_addr_d = addr_q;
                    wr_data_d = wdat_data;
                end
                if (done) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (issue) begin
                    rd_addr_d = addr_q;
                end
                if (pop) begin
                    deliver_d = deliver_q - 1'b1;
                end
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr_accept || issue) begin
            addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            beats_d = beats_q - 1'b1;
        end
    end

    // Reads are only issued while buffered plus in-flight beats leave a free slot,
    // so the buffer can never overflow even when the consumer stalls.
    always_comb begin
        cmd_ready   = init_q && (state_q == IDLE);
        busy        = (state_q != IDLE);
        wdat_ready  = (state_q == WRITE) && (beats_q != '0);
        wr_accept   = wdat_valid && wdat_ready;
        outstanding = CNT_W'(buf_occ);
        for (int unsigned i = 0; i <= RD_LAT; i++) begin
            outstanding = outstanding + CNT_W'(pipe_q[i]);
        end
        issue       = (state_q == READ) && (beats_q != '0) && !buf_full &&
                      (outstanding < CNT_W'(RBUF_DEPTH));
        push        = pipe_q[RD_LAT];
        rdat_valid  = !buf_empty;
        pop         = rdat_valid && rdat_ready;
        done        = ((state_q == WRITE) && (beats_q == '0) && wr_enbl_q) ||
                      ((state_q == READ) && (deliver_q == '0));
    end

    assign wr_enbl = wr_enbl_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_enbl = rd_enbl_q;
    assign rd_addr = rd_addr_q;

    ram_rd_buf #(
        .DEPTH (RBUF_DEPTH),
        .WIDTH (DWIDTH)
    ) u_rd_buf (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (rd_data),
        .pop       (pop),
        .pop_data  (rdat_data),
        .occ       (buf_occ),
        .empty     (buf_empty),
        .full      (buf_full)
    );

endmodule

// File: tb/tb_ram_burst_initiator.sv
// Directed and randomized bursts against a RAM model and a memory-image reference.
module tb_ram_burst_initiator;
    import ram_pkg::*;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned DWIDTH = 8;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned RBUF   = 4;
    localparam int unsigned AW     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0]     cmd_addr, cmd_len;
    logic              wdat_valid, wdat_ready;
    logic [DWIDTH-1:0] wdat_data;
    logic              rdat_valid, rdat_ready;
    logic [DWIDTH-1:0] rdat_data;
    logic              busy, done;
    logic              wr_enbl, rd_enbl;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [DWIDTH-1:0] wr_data, rd_data;

    logic [DWIDTH-1:0] ram      [DEPTH];
    logic [DWIDTH-1:0] seed_mem [DEPTH];
    logic [DWIDTH-1:0] ref_mem  [DEPTH];
    logic              ram_load;

    int tests = 0;
    int fails = 0;

    ram_burst_initiator #(
        .DEPTH      (DEPTH),
        .DWIDTH     (DWIDTH),
        .RD_LAT     (RD_LAT),
        .RBUF_DEPTH (RBUF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat_data  (wdat_data),
        .rdat_valid (rdat_valid),
        .rdat_ready (rdat_ready),
        .rdat_data  (rdat_data),
        .busy       (busy),
        .done       (done),
        .wr_enbl    (wr_enbl),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_enbl    (rd_enbl),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // RAM slave with one cycle read latency.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= seed_mem[i];
        end else begin
            if (wr_enbl) ram[wr_addr] <= wr_data;
            if (rd_enbl) rd_data <= ram[rd_addr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input bit w, input int unsigned addr, input int unsigned len);
        cmd_t c;
        int   n = 0;
        c.write   = w;
        c.addr    = AW'(addr);
        c.len     = AW'(len);
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_len   = c.len;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // mode 0: wdat_valid every cycle, 1: alternate cycles, 2: random gaps
    task automatic write_burst(input int unsigned addr, input int unsigned len,
                               input int mode, input bit fixed, input bit hold);
        logic [DWIDTH-1:0] d [DEPTH];
        int beats = len + 1;
        int sent = 0, seen = 0, cyc = 0;
        bit exp_we = 0, want, fin = 0;
        for (int k = 0; k < beats; k++) d[k] = fixed ? DWIDTH'(8'hA0 + k) : DWIDTH'($urandom);
        do_cmd(1'b1, addr, len);
        if (hold) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = AW'(addr);
            cmd_len   = AW'(len);
        end
        while (!fin && cyc < 4 * beats + 40) begin
            check("wr_enbl", 32'(wr_enbl), 32'(exp_we));
            check("rd_enbl_in_write", 32'(rd_enbl), 32'd0);
            check("busy_write", 32'(busy), 32'd1);
            check("cmd_ready_write", 32'(cmd_ready), 32'd0);
            if (exp_we) begin
                check("wr_addr", 32'(wr_addr), (addr + seen) % DEPTH);
                check("wr_data", 32'(wr_data), 32'(d[seen]));
            end
            check("wr_done", 32'(done), 32'(exp_we && (seen + 1 == beats)));
            if (exp_we) seen++;
            if (seen == beats) begin
                fin = 1;
            end else begin
                check("wdat_ready", 32'(wdat_ready), 32'(sent < beats));
                want = (sent < beats) &&
                       ((mode == 0) || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom % 4 != 0));
                wdat_valid = want || (sent == beats);
                wdat_data  = want ? d[sent] : DWIDTH'($urandom);
                exp_we     = want;
                if (want) sent++;
                @(negedge clk);
                cyc++;
            end
        end
        check("write_complete", 32'(seen), 32'(beats));
        @(negedge clk);
        check("busy_after_write", 32'(busy), 32'd0);
        check("cmd_ready_after_write", 32'(cmd_ready), 32'd1);
        check("wdat_ready_idle", 32'(wdat_ready), 32'd0);
        check("done_after_write", 32'(done), 32'd0);
        wdat_valid = 1'b0;
        for (int k = 0; k < beats; k++) begin
            ref_mem[(addr + k) % DEPTH] = d[k];
            check("ram_contents", 32'(ram[(addr + k) % DEPTH]), 32'(d[k]));
        end
    endtask

    // mode 0: rdat_ready always 1, 1: held 0 for 'stall' cycles then 1, 2: random
    task automatic read_burst(input int unsigned addr, input int unsigned len,
                              input int mode, input int stall);
        int beats = len + 1;
        int issued = 0, popped = 0, cyc = 0, first_en = -1, first_v = -1;
        bit prev_hold = 0, exp_done = 0, fin = 0, hs;
        logic [DWIDTH-1:0] prev_data = '0;
        do_cmd(1'b0, addr, len);
        wdat_valid = 1'b1;
        while (!fin && cyc < 10 * beats + 60) begin
            check("wr_enbl_in_read", 32'(wr_enbl), 32'd0);
            check("wdat_ready_in_read", 32'(wdat_ready), 32'd0);
            check("busy_read", 32'(busy), 32'd1);
            check("rd_done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                check("rdat_valid_at_done", 32'(rdat_valid), 32'd0);
                fin = 1;
            end else begin
                if (rd_enbl) begin
                    check("rd_addr", 32'(rd_addr), (addr + issued) % DEPTH);
                    if (first_en < 0) first_en = cyc;
                    issued++;
                end
                check("outstanding_cap", 32'(issued - popped <= RBUF), 32'd1);
                check("no_overissue", 32'(issued <= beats), 32'd1);
                if (prev_hold) begin
                    check("rdat_valid_held", 32'(rdat_valid), 32'd1);
                    check("rdat_data_stable", 32'(rdat_data), 32'(prev_data));
                end
                if (rdat_valid && first_v < 0) begin
                    first_v = cyc;
                    check("first_latency", 32'(first_v - first_en), RD_LAT + 1);
                end
                if (mode == 1 && cyc == stall)
                    check("stall_issue_cap", 32'(issued), (beats < RBUF) ? beats : RBUF);
                if (mode == 0 && first_v >= 0)
                    check("full_rate", 32'(rdat_valid), 32'd1);
                rdat_ready = (mode == 0) || (mode == 1 && cyc >= stall) ||
                             (mode == 2 && $urandom % 3 != 0);
                hs = rdat_valid && rdat_ready;
                if (hs) begin
                    check("rdat_data", 32'(rdat_data), 32'(ref_mem[(addr + popped) % DEPTH]));
                    popped++;
                    if (popped == beats) exp_done = 1;
                end
                prev_hold = rdat_valid && !rdat_ready;
                prev_data = rdat_data;
                @(negedge clk);
                cyc++;
            end
        end
        check("read_complete", 32'(popped), 32'(beats));
        wdat_valid = 1'b0;
        rdat_ready = 1'b0;
        @(negedge clk);
        check("busy_after_read", 32'(busy), 32'd0);
        check("cmd_ready_after_read", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        ram_load   = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        wdat_valid = 1'b0;
        wdat_data  = '0;
        rdat_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            seed_mem[i] = DWIDTH'($urandom);
            ref_mem[i]  = seed_mem[i];
        end
        repeat (2) @(negedge clk);
        ram_load = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_wdat_ready", 32'(wdat_ready), 32'd0);
        check("rst_rdat_valid", 32'(rdat_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_enbl", 32'(wr_enbl), 32'd0);
        check("rst_rd_enbl", 32'(rd_enbl), 32'd0);
        check("rst_rdat_data", 32'(rdat_data), 32'd0);
        rst = 1'b1;
        #1;
        check("cmd_ready_before_first_clk", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

        write_burst(32'h10, 3, 0, 1'b1, 1'b0);
        read_burst(32'h10, 3, 0, 0);

        write_burst(32'hFE, 2, 0, 1'b0, 1'b0);
        read_burst(32'hFE, 2, 0, 0);

        read_burst(32'h0C, 7, 1, 10);

        write_burst(32'h40, 2, 1, 1'b0, 1'b1);
        read_burst(32'h40, 2, 0, 0);

        // Abandon a read with two beats sitting in the buffer.
        do_cmd(1'b0, 32'h10, 7);
        rdat_ready = 1'b0;
        n = 0;
        while (!rdat_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midread_buffered", 32'(rdat_valid), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_rdat_valid", 32'(rdat_valid), 32'd0);
        check("midrst_rd_enbl", 32'(rd_enbl), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_rd_addr", 32'(rd_addr), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_rdat_data", 32'(rdat_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_midrst", 32'(cmd_ready), 32'd1);
        read_burst(32'h10, 3, 0, 0);

        write_burst(32'h80, 255, 0, 1'b0, 1'b0);
        read_burst(32'h00, 255, 2, 0);

        for (int t = 0; t < 6; t++) begin
            write_burst($urandom % DEPTH, $urandom % 12, 2, 1'b0, 1'b0);
            read_burst($urandom % DEPTH, $urandom % 12, 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
